// File: rtl/pacman_pkg.sv
// Shared constants for the sprite engine: one-hot direction codes, sprite indices,
// playfield bounds and the sweep FSM state type.
package pacman_pkg;

   localparam logic [3:0] DIR_NONE = 4'b0000;
   localparam logic [3:0] DIR_R    = 4'b0001;
   localparam logic [3:0] DIR_U    = 4'b0010;
   localparam logic [3:0] DIR_D    = 4'b0100;
   localparam logic [3:0] DIR_L    = 4'b1000;

   localparam int PACMAN = 0;
   localparam int BLINKY = 1;
   localparam int PINKY  = 2;
   localparam int INKY   = 3;
   localparam int CLYDE  = 4;

   localparam int SPR_STEP = 16;
   localparam int PF_X_MIN = 343;
   localparam int PF_X_MAX = 1607;
   localparam int PF_Y_MIN = 34;
   localparam int PF_Y_MAX = 818;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SEL,
      ST_QRY,
      ST_APPLY
   } sweep_state_t;

   function automatic logic is_one_hot4(input logic [3:0] d);
      return (d != 4'b0000) && ((d & (d - 4'b0001)) == 4'b0000);
   endfunction

endpackage

// File: rtl/sprite_step_calc.sv
// Next grid position for one step in a one-hot direction, wrapping at the playfield edges.
// Comparisons use one extra bit so the increment cannot overflow.
module sprite_step_calc
   import pacman_pkg::*;
#(
   parameter int X_W   = 11,
   parameter int Y_W   = 10,
   parameter int STEP  = SPR_STEP,
   parameter int X_MIN = PF_X_MIN,
   parameter int X_MAX = PF_X_MAX,
   parameter int Y_MIN = PF_Y_MIN,
   parameter int Y_MAX = PF_Y_MAX
) (
   input  logic [X_W-1:0] x,
   input  logic [Y_W-1:0] y,
   input  logic [3:0]     dir,
   output logic [X_W-1:0] next_x,
   output logic [Y_W-1:0] next_y
);

   localparam logic [X_W:0] X_STEP_E = (X_W+1)'(STEP);
   localparam logic [X_W:0] X_HI_E   = (X_W+1)'(X_MAX);
   localparam logic [X_W:0] X_LO_S_E = (X_W+1)'(X_MIN + STEP);
   localparam logic [Y_W:0] Y_STEP_E = (Y_W+1)'(STEP);
   localparam logic [Y_W:0] Y_HI_E   = (Y_W+1)'(Y_MAX);
   localparam logic [Y_W:0] Y_LO_S_E = (Y_W+1)'(Y_MIN + STEP);

   logic [X_W:0] x_ext;
   logic [X_W:0] x_inc;
   logic [Y_W:0] y_ext;
   logic [Y_W:0] y_inc;

   assign x_ext = {1'b0, x};
   assign y_ext = {1'b0, y};
   assign x_inc = x_ext + X_STEP_E;
   assign y_inc = y_ext + Y_STEP_E;

   always_comb begin
      next_x = x;
      next_y = y;
      case (dir)
         DIR_R: next_x = (x_inc > X_HI_E) ? X_W'(X_MIN) : x_inc[X_W-1:0];
         DIR_L: next_x = (x_ext < X_LO_S_E) ? X_W'(X_MAX) : x - X_W'(STEP);
         DIR_U: next_y = (y_ext < Y_LO_S_E) ? Y_W'(Y_MAX) : y - Y_W'(STEP);
         DIR_D: next_y = (y_inc > Y_HI_E) ? Y_W'(Y_MIN) : y_inc[Y_W-1:0];
         default: ;
      endcase
   end

endmodule

// File: rtl/sprite_motion_engine.sv
// Round-robin grid-step engine: once per frame_tick each enabled sprite queries the map
// detector for legal moves and applies queued turn / current direction with edge wrap.
module sprite_motion_engine
   import pacman_pkg::*;
#(
   parameter int N_SPR = CLYDE + 1,
   parameter int X_W   = 11,
   parameter int Y_W   = 10,
   parameter int STEP  = SPR_STEP,
   parameter int X_MIN = PF_X_MIN,
   parameter int X_MAX = PF_X_MAX,
   parameter int Y_MIN = PF_Y_MIN,
   parameter int Y_MAX = PF_Y_MAX,
   parameter logic [X_W*N_SPR-1:0] RST_X = {11'd1415, 11'd1031, 11'd439, 11'd1399, 11'd1367},
   parameter logic [Y_W*N_SPR-1:0] RST_Y = {10'd66, 10'd402, 10'd434, 10'd130, 10'd306}
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 frame_tick,
   input  logic [4*N_SPR-1:0]   dir_req,
   input  logic [N_SPR-1:0]     enable,
   input  logic [N_SPR-1:0]     respawn,
   output logic                 q_req,
   output logic [X_W-1:0]       q_x,
   output logic [Y_W-1:0]       q_y,
   input  logic                 q_ack,
   input  logic [3:0]           q_moves,
   output logic [X_W*N_SPR-1:0] pos_x,
   output logic [Y_W*N_SPR-1:0] pos_y,
   output logic [4*N_SPR-1:0]   cur_dir,
   output logic                 busy,
   output logic                 sweep_done,
   output logic                 overrun
);

   localparam int IDX_W = (N_SPR > 1) ? $clog2(N_SPR) : 1;

   sweep_state_t     state_reg, state_next;
   logic [IDX_W-1:0] idx_reg, idx_next;
   logic [X_W-1:0]   q_x_reg;
   logic [Y_W-1:0]   q_y_reg;
   logic [3:0]       moves_reg;
   logic             discard_reg;
   logic             pending_reg, pending_next;
   logic             sweep_done_reg, done_next;
   logic             overrun_reg, overrun_next;
   logic             load_q;
   logic             apply_en;
   logic             last_idx;

   logic [X_W-1:0] pos_x_arr   [N_SPR];
   logic [Y_W-1:0] pos_y_arr   [N_SPR];
   logic [3:0]     cur_dir_arr [N_SPR];
   logic [3:0]     queued_arr  [N_SPR];

   logic [3:0]     sel_queued;
   logic [3:0]     sel_dir;
   logic [3:0]     step_dir;
   logic [X_W-1:0] step_x;
   logic [Y_W-1:0] step_y;

   assign last_idx = (idx_reg == IDX_W'(N_SPR - 1));

   always_comb begin
      state_next   = state_reg;
      idx_next     = idx_reg;
      done_next    = 1'b0;
      load_q       = 1'b0;
      apply_en     = 1'b0;
      pending_next = pending_reg;
      overrun_next = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (frame_tick || pending_reg) begin
               state_next = ST_SEL;
               idx_next   = '0;
            end
         end
         ST_SEL: begin
            if (enable[idx_reg]) begin
               state_next = ST_QRY;
               load_q     = 1'b1;
            end else if (last_idx) begin
               state_next = ST_IDLE;
               done_next  = 1'b1;
            end else begin
               idx_next = idx_reg + 1'b1;
            end
         end
         ST_QRY: begin
            if (q_ack) state_next = ST_APPLY;
         end
         ST_APPLY: begin
            apply_en = 1'b1;
            if (last_idx) begin
               state_next = ST_IDLE;
               done_next  = 1'b1;
            end else begin
               state_next = ST_SEL;
               idx_next   = idx_reg + 1'b1;
            end
         end
         default: state_next = ST_IDLE;
      endcase

      // In IDLE a pending tick is consumed; a coincident new tick becomes the next pending one.
      if (state_reg == ST_IDLE) begin
         pending_next = pending_reg && frame_tick;
      end else if (frame_tick) begin
         if (pending_reg) overrun_next = 1'b1;
         else             pending_next = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg      <= ST_IDLE;
         idx_reg        <= '0;
         q_x_reg        <= '0;
         q_y_reg        <= '0;
         moves_reg      <= '0;
         discard_reg    <= 1'b0;
         pending_reg    <= 1'b0;
         sweep_done_reg <= 1'b0;
         overrun_reg    <= 1'b0;
      end else begin
         state_reg      <= state_next;
         idx_reg        <= idx_next;
         pending_reg    <= pending_next;
         sweep_done_reg <= done_next;
         overrun_reg    <= overrun_next;
         if (load_q) begin
            q_x_reg <= pos_x_arr[idx_reg];
            q_y_reg <= pos_y_arr[idx_reg];
         end
         if (state_reg == ST_QRY && q_ack) moves_reg <= q_moves;
         // A respawn of the sprite being queried invalidates its pending APPLY.
         if (state_reg == ST_APPLY)
            discard_reg <= 1'b0;
         else if ((state_reg == ST_QRY || (state_reg == ST_SEL && enable[idx_reg])) && respawn[idx_reg])
            discard_reg <= 1'b1;
      end
   end

   assign sel_queued = queued_arr[idx_reg];
   assign sel_dir    = cur_dir_arr[idx_reg];

   always_comb begin
      step_dir = DIR_NONE;
      if ((sel_queued & moves_reg) != 4'b0000)
         step_dir = sel_queued;
      else if ((sel_dir & moves_reg) != 4'b0000)
         step_dir = sel_dir;
   end

   sprite_step_calc #(
      .X_W   (X_W),
      .Y_W   (Y_W),
      .STEP  (STEP),
      .X_MIN (X_MIN),
      .X_MAX (X_MAX),
      .Y_MIN (Y_MIN),
      .Y_MAX (Y_MAX)
   ) u_step (
      .x      (q_x_reg),
      .y      (q_y_reg),
      .dir    (step_dir),
      .next_x (step_x),
      .next_y (step_y)
   );

   genvar gi;
   generate
      for (gi = 0; gi < N_SPR; gi++) begin : g_spr
         logic [X_W-1:0] px_reg;
         logic [Y_W-1:0] py_reg;
         logic [3:0]     dir_reg;
         logic [3:0]     queued_reg;
         logic [3:0]     req;
         logic           hit;

         assign req = dir_req[gi*4 +: 4];
         assign hit = apply_en && !discard_reg && (idx_reg == IDX_W'(gi));

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               px_reg     <= RST_X[gi*X_W +: X_W];
               py_reg     <= RST_Y[gi*Y_W +: Y_W];
               dir_reg    <= DIR_NONE;
               queued_reg <= DIR_NONE;
            end else if (respawn[gi]) begin
               px_reg     <= RST_X[gi*X_W +: X_W];
               py_reg     <= RST_Y[gi*Y_W +: Y_W];
               dir_reg    <= DIR_NONE;
               queued_reg <= DIR_NONE;
            end else begin
               if (is_one_hot4(req)) queued_reg <= req;
               if (hit) begin
                  px_reg  <= step_x;
                  py_reg  <= step_y;
                  dir_reg <= step_dir;
               end
            end
         end

         assign pos_x_arr[gi]         = px_reg;
         assign pos_y_arr[gi]         = py_reg;
         assign cur_dir_arr[gi]       = dir_reg;
         assign queued_arr[gi]        = queued_reg;
         assign pos_x[gi*X_W +: X_W]  = px_reg;
         assign pos_y[gi*Y_W +: Y_W]  = py_reg;
         assign cur_dir[gi*4 +: 4]    = dir_reg;
      end
   endgenerate

   assign q_req      = (state_reg == ST_QRY);
   assign q_x        = q_x_reg;
   assign q_y        = q_y_reg;
   assign busy       = (state_reg != ST_IDLE);
   assign sweep_done = sweep_done_reg;
   assign overrun    = overrun_reg;

endmodule

// File: tb/tb_sprite_motion_engine.sv
// Scoreboard bench: each sweep pushes the expected sprite state; a monitor pops and
// compares on every sweep_done, while a responder answers the move queries.
module tb_sprite_motion_engine;

   localparam int N = 5;
   localparam logic [3:0] R = 4'b0001, U = 4'b0010, D = 4'b0100, L = 4'b1000;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          frame_tick = 1'b0;
   logic [4*N-1:0] dir_req = '0;
   logic [N-1:0]  enable = '0;
   logic [N-1:0]  respawn = '0;
   logic          q_req;
   logic [10:0]   q_x;
   logic [9:0]    q_y;
   logic          q_ack = 1'b0;
   logic [3:0]    q_moves = 4'b0000;
   logic [11*N-1:0] pos_x;
   logic [10*N-1:0] pos_y;
   logic [4*N-1:0]  cur_dir;
   logic          busy;
   logic          sweep_done;
   logic          overrun;

   typedef struct packed {
      logic [11*N-1:0] px;
      logic [10*N-1:0] py;
      logic [4*N-1:0]  dir;
   } snap_t;

   snap_t exp_q[$];
   snap_t mon_s;
   int errors = 0;
   int checks = 0;
   int ex[N];
   int ey[N];
   logic [3:0] ed[N];
   int ack_delay = 1;
   logic [3:0] resp_moves = 4'hF;
   int done_cnt = 0;
   int overrun_cnt = 0;
   int sweeps_issued = 0;
   logic [10:0] qx0;
   logic [9:0]  qy0;

   always #5 clk = ~clk;

   sprite_motion_engine dut (
      .clk        (clk),
      .rst        (rst),
      .frame_tick (frame_tick),
      .dir_req    (dir_req),
      .enable     (enable),
      .respawn    (respawn),
      .q_req      (q_req),
      .q_x        (q_x),
      .q_y        (q_y),
      .q_ack      (q_ack),
      .q_moves    (q_moves),
      .pos_x      (pos_x),
      .pos_y      (pos_y),
      .cur_dir    (cur_dir),
      .busy       (busy),
      .sweep_done (sweep_done),
      .overrun    (overrun)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Monitor: one scoreboard entry per sweep_done pulse.
   always @(negedge clk) begin
      if (overrun) overrun_cnt++;
      if (sweep_done) begin
         done_cnt++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_sweep_done actual=1 required=0");
         end else begin
            mon_s = exp_q.pop_front();
            for (int i = 0; i < N; i++) begin
               chk($sformatf("sweep%0d_x%0d", done_cnt, i), pos_x[i*11 +: 11], mon_s.px[i*11 +: 11]);
               chk($sformatf("sweep%0d_y%0d", done_cnt, i), pos_y[i*10 +: 10], mon_s.py[i*10 +: 10]);
               chk($sformatf("sweep%0d_dir%0d", done_cnt, i), cur_dir[i*4 +: 4], mon_s.dir[i*4 +: 4]);
            end
            $display("sweep %0d checked: x0=%0d y0=%0d dir0=%b", done_cnt,
                     pos_x[10:0], pos_y[9:0], cur_dir[3:0]);
         end
      end
   end

   // Map-detector model: answers each query after ack_delay cycles.
   initial begin
      forever begin
         @(negedge clk);
         if (q_req && !q_ack) begin
            qx0 = q_x;
            qy0 = q_y;
            repeat (ack_delay) @(negedge clk);
            chk("q_xy_stable", {q_x, q_y}, {qx0, qy0});
            q_moves = resp_moves;
            q_ack   = 1'b1;
            @(negedge clk);
            q_ack   = 1'b0;
            q_moves = 4'b0000;
         end
      end
   end

   task automatic set_dir(input int s, input logic [3:0] d);
      dir_req[s*4 +: 4] = d;
   endtask

   task automatic push_exp();
      snap_t s;
      for (int i = 0; i < N; i++) begin
         s.px[i*11 +: 11] = 11'(ex[i]);
         s.py[i*10 +: 10] = 10'(ey[i]);
         s.dir[i*4 +: 4]  = ed[i];
      end
      exp_q.push_back(s);
      sweeps_issued++;
   endtask

   task automatic tick();
      frame_tick = 1'b1;
      @(posedge clk); #1;
      frame_tick = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      @(posedge clk); #1;
      while ((busy || exp_q.size() != 0) && n < 3000) begin
         @(posedge clk); #1;
         n++;
      end
      chk({name, "_timeout"}, (n >= 3000), 0);
   endtask

   task automatic sweep(input string name);
      push_exp();
      tick();
      wait_idle(name);
   endtask

   initial begin
      ex = '{1367, 1399, 439, 1031, 1415};
      ey = '{306, 130, 434, 402, 66};
      for (int i = 0; i < N; i++) ed[i] = 4'b0000;

      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("rst_x0", pos_x[10:0], 1367);
      chk("rst_y0", pos_y[9:0], 306);
      chk("rst_x2", pos_x[32:22], 439);
      chk("rst_y4", pos_y[49:40], 66);
      chk("rst_dir", cur_dir, 0);
      chk("rst_q_req", q_req, 0);
      chk("rst_busy", busy, 0);
      chk("rst_sweep_done", sweep_done, 0);
      chk("rst_overrun", overrun, 0);
      @(posedge clk); #1;

      // Single sprite step right
      enable = 5'b00001;
      set_dir(0, R);
      @(posedge clk); #1;
      ex[0] = 1383; ed[0] = R;
      sweep("t2");
      chk("t2_done_once", done_cnt, 1);

      // Cornering: queued U blocked, keep going R; then U allowed
      set_dir(0, U);
      resp_moves = 4'b0001;
      ex[0] = 1399; ed[0] = R;
      sweep("t3a");
      resp_moves = 4'b0010;
      ey[0] = 290; ed[0] = U;
      sweep("t3b");

      // Wrap in all four directions
      resp_moves = 4'hF;
      set_dir(0, R);
      ed[0] = R;
      for (int k = 0; k < 13; k++) begin
         ex[0] = ex[0] + 16;
         sweep("t4r");
      end
      ex[0] = 343;
      sweep("t4_wrap_r");
      set_dir(0, L);
      ex[0] = 1607; ed[0] = L;
      sweep("t4_wrap_l");
      set_dir(0, U);
      ed[0] = U;
      for (int k = 0; k < 16; k++) begin
         ey[0] = ey[0] - 16;
         sweep("t4u");
      end
      ey[0] = 818;
      sweep("t4_wrap_u");
      set_dir(0, D);
      ey[0] = 34; ed[0] = D;
      sweep("t4_wrap_d");

      // Three ticks in one long sweep: one extra sweep, one overrun
      set_dir(2, R);
      set_dir(3, L);
      enable = 5'b11111;
      ack_delay = 10;
      @(posedge clk); #1;
      ey[0] = 50; ex[2] = 455; ed[2] = R; ex[3] = 1015; ed[3] = L;
      push_exp();
      ey[0] = 66; ex[2] = 471; ex[3] = 999;
      push_exp();
      tick();
      repeat (3) @(posedge clk); #1;
      tick();
      repeat (3) @(posedge clk); #1;
      tick();
      wait_idle("t5");
      chk("t5_overrun_once", overrun_cnt, 1);

      // Respawn sprite 2 during its query; multi-hot request on sprite 0 ignored
      set_dir(2, 4'b0000);
      set_dir(0, 4'b0011);
      ack_delay = 4;
      @(posedge clk); #1;
      ey[0] = 82; ex[2] = 439; ey[2] = 434; ed[2] = 4'b0000; ex[3] = 983;
      push_exp();
      tick();
      begin
         int n = 0;
         while (!(q_req && q_x == 11'd471 && q_y == 10'd434) && n < 500) begin
            @(posedge clk); #1;
            n++;
         end
         chk("t6_found_query2", (n >= 500), 0);
      end
      respawn = 5'b00100;
      @(posedge clk); #1;
      respawn = 5'b00000;
      wait_idle("t6");

      // Respawn coinciding with a request: queued is cleared, sprite 1 stays put
      set_dir(1, R);
      respawn = 5'b00010;
      @(posedge clk); #1;
      respawn = 5'b00000;
      set_dir(1, 4'b0000);
      ey[0] = 98; ex[3] = 967;
      sweep("t7");

      chk("total_sweeps", done_cnt, sweeps_issued);
      chk("scoreboard_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
